// File: rtl/bolt_slot_arbiter.sv
// bolt_slot_arbiter: shared bolt-slot pool with player/invader round-robin grant.
// Define BOLT_STATS_EN to build the plrShots/invShots spawn counters.
module bolt_slot_arbiter #(
  parameter int SLOTS    = 4,
  parameter int PLR_MAX  = 2,
  parameter int COOLDOWN = 3
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     enable,
  input  logic                     frmTick,
  input  logic                     plrFire,
  input  logic                     invFire,
  input  logic [SLOTS-1:0]         slotKill,
  output logic [SLOTS-1:0]         slotExs,
  output logic [SLOTS-1:0]         slotOwn,
  output logic                     spawnVld,
  output logic [$clog2(SLOTS)-1:0] spawnIdx,
  output logic                     spawnOwn,
  output logic [$clog2(SLOTS):0]   plrCnt,
  output logic [15:0]              plrShots,
  output logic [15:0]              invShots
);

  localparam int IW = $clog2(SLOTS);
  localparam int NW = IW + 1;
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [SLOTS-1:0] slot_exs_q, slot_exs_d;
  logic [SLOTS-1:0] slot_own_q, slot_own_d;
  logic             spawn_vld_q, spawn_vld_d;
  logic [IW-1:0]    spawn_idx_q, spawn_idx_d;
  logic             spawn_own_q, spawn_own_d;
  logic             last_own_q, last_own_d;
  logic             plr_pend_q, plr_pend_d;
  logic             inv_pend_q, inv_pend_d;
  logic [CW-1:0]    cd_q, cd_d;

  logic [NW-1:0]    plr_cnt;
  logic             any_free;
  logic [IW-1:0]    free_idx;
  logic             plr_req, inv_req;
  logic             p_elig, i_elig;
  logic             grant, grant_own;

  // live player bolts and lowest free slot from registered occupancy
  always_comb begin
    plr_cnt  = '0;
    free_idx = '0;
    any_free = ~&slot_exs_q;
    for (int i = 0; i < SLOTS; i++) begin
      plr_cnt = plr_cnt + NW'(slot_exs_q[i] & slot_own_q[i]);
    end
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!slot_exs_q[i]) free_idx = IW'(i);
    end
  end

  // request qualification and single-grant arbitration
  always_comb begin
    plr_req   = plr_pend_q | (plrFire & (cd_q == '0));
    inv_req   = inv_pend_q | invFire;
    p_elig    = enable & plr_req & any_free
              & (plr_cnt < NW'(PLR_MAX));
    i_elig    = enable & inv_req & any_free;
    grant     = p_elig | i_elig;
    grant_own = (p_elig & i_elig) ? ~last_own_q : p_elig;
  end

  // next state: kills, grant, pending, cooldown, disable clear
  always_comb begin
    slot_exs_d  = slot_exs_q & ~slotKill;
    slot_own_d  = slot_own_q & ~slotKill;
    spawn_vld_d = 1'b0;
    spawn_idx_d = spawn_idx_q;
    spawn_own_d = spawn_own_q;
    last_own_d  = last_own_q;
    plr_pend_d  = plr_req & ~(grant & grant_own);
    inv_pend_d  = inv_req & ~(grant & ~grant_own);
    cd_d        = cd_q;
    if (frmTick && (cd_q != '0)) cd_d = cd_q - CW'(1);
    if (grant) begin
      slot_exs_d[free_idx] = 1'b1;
      slot_own_d[free_idx] = grant_own;
      spawn_vld_d          = 1'b1;
      spawn_idx_d          = free_idx;
      spawn_own_d          = grant_own;
      last_own_d           = grant_own;
      if (grant_own) cd_d = CW'(COOLDOWN);
    end
    if (!enable) begin
      slot_exs_d  = '0;
      slot_own_d  = '0;
      plr_pend_d  = 1'b0;
      inv_pend_d  = 1'b0;
      cd_d        = '0;
      spawn_vld_d = 1'b0;
    end
  end

  // arbiter state registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      slot_exs_q  <= '0;
      slot_own_q  <= '0;
      spawn_vld_q <= 1'b0;
      spawn_idx_q <= '0;
      spawn_own_q <= 1'b0;
      last_own_q  <= 1'b0;
      plr_pend_q  <= 1'b0;
      inv_pend_q  <= 1'b0;
      cd_q        <= '0;
    end else begin
      slot_exs_q  <= slot_exs_d;
      slot_own_q  <= slot_own_d;
      spawn_vld_q <= spawn_vld_d;
      spawn_idx_q <= spawn_idx_d;
      spawn_own_q <= spawn_own_d;
      last_own_q  <= last_own_d;
      plr_pend_q  <= plr_pend_d;
      inv_pend_q  <= inv_pend_d;
      cd_q        <= cd_d;
    end
  end

`ifdef BOLT_STATS_EN
  logic [15:0] plr_shots_q, plr_shots_d;
  logic [15:0] inv_shots_q, inv_shots_d;

  // saturating spawn counters per owner
  always_comb begin
    plr_shots_d = plr_shots_q;
    inv_shots_d = inv_shots_q;
    if (grant && grant_own && plr_shots_q != 16'hFFFF)
      plr_shots_d = plr_shots_q + 16'd1;
    if (grant && !grant_own && inv_shots_q != 16'hFFFF)
      inv_shots_d = inv_shots_q + 16'd1;
  end

  // counter registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      plr_shots_q <= '0;
      inv_shots_q <= '0;
    end else begin
      plr_shots_q <= plr_shots_d;
      inv_shots_q <= inv_shots_d;
    end
  end

  assign plrShots = plr_shots_q;
  assign invShots = inv_shots_q;
`else
  assign plrShots = 16'h0000;
  assign invShots = 16'h0000;
`endif

  assign slotExs  = slot_exs_q;
  assign slotOwn  = slot_own_q;
  assign spawnVld = spawn_vld_q;
  assign spawnIdx = spawn_idx_q;
  assign spawnOwn = spawn_own_q;
  assign plrCnt   = plr_cnt;

endmodule

// File: tb/tb_bolt_slot_arbiter.sv
// tb_bolt_slot_arbiter: directed checks of slot grant, pend, cooldown,
// kill, disable and async reset behaviour for the default 4-slot pool.
module tb_bolt_slot_arbiter;

`ifdef BOLT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetN;
  logic        enable;
  logic        frmTick;
  logic        plrFire;
  logic        invFire;
  logic [3:0]  slotKill;
  logic [3:0]  slotExs;
  logic [3:0]  slotOwn;
  logic        spawnVld;
  logic [1:0]  spawnIdx;
  logic        spawnOwn;
  logic [2:0]  plrCnt;
  logic [15:0] plrShots;
  logic [15:0] invShots;

  int checks = 0;
  int errors = 0;

  bolt_slot_arbiter #(
    .SLOTS(4), .PLR_MAX(2), .COOLDOWN(3)
  ) dut (
    .clk(clk), .resetN(resetN), .enable(enable),
    .frmTick(frmTick), .plrFire(plrFire), .invFire(invFire),
    .slotKill(slotKill), .slotExs(slotExs), .slotOwn(slotOwn),
    .spawnVld(spawnVld), .spawnIdx(spawnIdx), .spawnOwn(spawnOwn),
    .plrCnt(plrCnt), .plrShots(plrShots), .invShots(invShots)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    frmTick = 1'b1;
    repeat (n) tick();
    frmTick = 1'b0;
  endtask

  task automatic spawn(input string tag, input logic own,
                       input logic [1:0] idx);
    chk({tag, "_vld"}, spawnVld, 1'b1);
    chk({tag, "_own"}, spawnOwn, own);
    chk({tag, "_idx"}, spawnIdx, idx);
  endtask

  task automatic rst();
    resetN = 1'b0;
    enable = 1'b0;
    frmTick = 1'b0;
    plrFire = 1'b0;
    invFire = 1'b0;
    slotKill = '0;
    #1;
    repeat (2) tick();
    resetN = 1'b1;
    enable = 1'b1;
  endtask

  initial begin
    resetN = 1'b1;
    enable = 1'b0;
    frmTick = 1'b0;
    plrFire = 1'b0;
    invFire = 1'b0;
    slotKill = '0;
    #2;
    rst();
    chk("rst_exs", slotExs, 4'b0000);
    chk("rst_own", slotOwn, 4'b0000);
    chk("rst_vld", spawnVld, 1'b0);
    chk("rst_idx", spawnIdx, 2'd0);
    chk("rst_sown", spawnOwn, 1'b0);
    chk("rst_cnt", plrCnt, 3'd0);
    chk("rst_pshots", plrShots, 16'd0);
    chk("rst_ishots", invShots, 16'd0);

    // single player fire
    plrFire = 1'b1; tick(); plrFire = 1'b0;
    spawn("t1", 1'b1, 2'd0);
    chk("t1_exs", slotExs, 4'b0001);
    chk("t1_cnt", plrCnt, 3'd1);
    chk("t1_pshots", plrShots, STATS ? 16'd1 : 16'd0);

    // tie after reset: player first, invader next cycle
    rst();
    plrFire = 1'b1; invFire = 1'b1; tick();
    plrFire = 1'b0; invFire = 1'b0;
    spawn("t2a", 1'b1, 2'd0);
    tick();
    spawn("t2b", 1'b0, 2'd1);
    chk("t2b_exs", slotExs, 4'b0011);
    chk("t2b_own", slotOwn, 4'b0001);
    tick();
    chk("t2_idle", spawnVld, 1'b0);
    frames(3);
    slotKill = 4'b0011; tick(); slotKill = '0;
    chk("t2_multikill", slotExs, 4'b0000);
    plrFire = 1'b1; tick(); plrFire = 1'b0;
    spawn("t2c", 1'b1, 2'd0);
    frames(3);
    plrFire = 1'b1; invFire = 1'b1; tick();
    plrFire = 1'b0; invFire = 1'b0;
    spawn("t2d", 1'b0, 2'd1);
    tick();
    spawn("t2e", 1'b1, 2'd2);
    chk("t2e_exs", slotExs, 4'b0111);
    chk("t2e_own", slotOwn, 4'b0101);
    chk("t2e_cnt", plrCnt, 3'd2);

    // full pool: invader pends until a kill frees slot 2
    invFire = 1'b1; tick(); invFire = 1'b0;
    spawn("t3a", 1'b0, 2'd3);
    chk("t3a_exs", slotExs, 4'b1111);
    invFire = 1'b1; tick(); invFire = 1'b0;
    chk("t3_full_vld", spawnVld, 1'b0);
    slotKill = 4'b0100; tick(); slotKill = '0;
    chk("t3_kill_exs", slotExs, 4'b1011);
    chk("t3_kill_vld", spawnVld, 1'b0);
    tick();
    spawn("t3b", 1'b0, 2'd2);
    chk("t3b_exs", slotExs, 4'b1111);
    chk("t3b_cnt", plrCnt, 3'd1);

    // cooldown: fires dropped until three frames have passed
    rst();
    plrFire = 1'b1; tick(); plrFire = 1'b0;
    spawn("t4a", 1'b1, 2'd0);
    frames(1);
    plrFire = 1'b1; tick(); plrFire = 1'b0;
    chk("t4_drop1", spawnVld, 1'b0);
    tick();
    chk("t4_nopend", spawnVld, 1'b0);
    chk("t4_nopend_exs", slotExs, 4'b0001);
    frames(1);
    plrFire = 1'b1; tick(); plrFire = 1'b0;
    chk("t4_drop2", spawnVld, 1'b0);
    frames(1);
    plrFire = 1'b1; tick(); plrFire = 1'b0;
    spawn("t4b", 1'b1, 2'd1);
    chk("t4b_cnt", plrCnt, 3'd2);

    // player quota: third fire pends, invader still served
    frames(3);
    plrFire = 1'b1; tick(); plrFire = 1'b0;
    chk("t5_quota_vld", spawnVld, 1'b0);
    chk("t5_quota_cnt", plrCnt, 3'd2);
    invFire = 1'b1; tick(); invFire = 1'b0;
    spawn("t5a", 1'b0, 2'd2);
    slotKill = 4'b0001; tick(); slotKill = '0;
    chk("t5_kill_vld", spawnVld, 1'b0);
    chk("t5_kill_exs", slotExs, 4'b0110);
    tick();
    spawn("t5b", 1'b1, 2'd0);
    chk("t5b_exs", slotExs, 4'b0111);
    chk("t5b_cnt", plrCnt, 3'd2);

    // kill on a free slot is ignored
    slotKill = 4'b1000; tick(); slotKill = '0;
    chk("t6_freekill", slotExs, 4'b0111);

    // disable clears pool, pends and cooldown; counters hold
    enable = 1'b0; plrFire = 1'b1; invFire = 1'b1; tick();
    chk("t6_dis_exs", slotExs, 4'b0000);
    chk("t6_dis_own", slotOwn, 4'b0000);
    chk("t6_dis_vld", spawnVld, 1'b0);
    chk("t6_dis_cnt", plrCnt, 3'd0);
    chk("t6_dis_pshots", plrShots, STATS ? 16'd3 : 16'd0);
    chk("t6_dis_ishots", invShots, STATS ? 16'd1 : 16'd0);
    tick();
    chk("t6_dis2_vld", spawnVld, 1'b0);
    chk("t6_dis2_exs", slotExs, 4'b0000);
    plrFire = 1'b0; invFire = 1'b0; enable = 1'b1; tick();
    chk("t6_nopend", spawnVld, 1'b0);
    plrFire = 1'b1; tick(); plrFire = 1'b0;
    spawn("t6a", 1'b1, 2'd0);
    chk("t6a_pshots", plrShots, STATS ? 16'd4 : 16'd0);

    // asynchronous reset while a spawn pulse is live
    invFire = 1'b1; tick(); invFire = 1'b0;
    spawn("t6b", 1'b0, 2'd1);
    #2 resetN = 1'b0;
    #1;
    chk("t6_ar_vld", spawnVld, 1'b0);
    chk("t6_ar_exs", slotExs, 4'b0000);
    chk("t6_ar_own", slotOwn, 4'b0000);
    chk("t6_ar_idx", spawnIdx, 2'd0);
    chk("t6_ar_sown", spawnOwn, 1'b0);
    chk("t6_ar_cnt", plrCnt, 3'd0);
    chk("t6_ar_pshots", plrShots, 16'd0);
    chk("t6_ar_ishots", invShots, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
